decode_issue: RTL and testbench

- Producer side of the execute-stage operand interface.
- Accepts fetched 16-bit WISC instructions over a valid/ready handshake and splits them into opcode, funct and immediate fields.
- Reads the 8x16 register file held inside this block and issues a registered operand bundle (opcode, funct, Rs/Rt data, PC, immediate) to the ALU stage.
- Applies write-back from the end of the pipe and stalls on read-after-write hazards using per-register pending counters.

---
 rtl/wisc_pkg.sv | 71 +++++++
 rtl/regfile_8x16.sv | 32 +++
 rtl/decode_issue.sv | 123 ++++++++++++
 tb/tb_decode_issue.sv | 352 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wisc_pkg.sv
// Shared WISC definitions: opcode encodings, instruction field positions and the
// small decode helpers used by the issue stage.
package wisc_pkg;
    typedef logic [2:0]  regspec_t;
    typedef logic [15:0] word_t;
    typedef logic [4:0]  opcode_t;

    typedef enum logic [4:0] {
        OP_HALT  = 5'b00000, OP_NOP   = 5'b00001, OP_SIIC  = 5'b00010, OP_RTI   = 5'b00011,
        OP_J     = 5'b00100, OP_JR    = 5'b00101, OP_JAL   = 5'b00110, OP_JALR  = 5'b00111,
        OP_ADDI  = 5'b01000, OP_SUBI  = 5'b01001, OP_XORI  = 5'b01010, OP_ANDNI = 5'b01011,
        OP_BEQZ  = 5'b01100, OP_BNEZ  = 5'b01101, OP_BLTZ  = 5'b01110, OP_BGEZ  = 5'b01111,
        OP_ST    = 5'b10000, OP_LD    = 5'b10001, OP_SLBI  = 5'b10010, OP_STU   = 5'b10011,
        OP_ROLI  = 5'b10100, OP_SLLI  = 5'b10101, OP_RORI  = 5'b10110, OP_SRLI  = 5'b10111,
        OP_LBI   = 5'b11000, OP_BTR   = 5'b11001, OP_SHIFT = 5'b11010, OP_ARITH = 5'b11011,
        OP_SEQ   = 5'b11100, OP_SLT   = 5'b11101, OP_SLE   = 5'b11110, OP_SCO   = 5'b11111
    } opcode_e;

    localparam int OPC_LSB = 11;
    localparam int RS_LSB  = 8;
    localparam int RT_LSB  = 5;
    localparam int RD_LSB  = 2;
    localparam int IMM_W   = 11;

    typedef struct packed {
        logic     en;
        regspec_t rd;
    } dest_t;

    function automatic opcode_t opcode_of(input word_t instr);
        return instr[OPC_LSB +: 5];
    endfunction

    function automatic regspec_t rs_of(input word_t instr);
        return instr[RS_LSB +: 3];
    endfunction

    function automatic regspec_t rt_of(input word_t instr);
        return instr[RT_LSB +: 3];
    endfunction

    function automatic dest_t decode_dest(input word_t instr);
        dest_t d;
        d.en = 1'b1;
        d.rd = instr[RD_LSB +: 3];
        casez (opcode_of(instr))
            OP_ARITH, OP_SHIFT, 5'b111??:         d.rd = instr[RD_LSB +: 3];
            5'b010??, 5'b101??, OP_LD, OP_BTR:    d.rd = instr[RT_LSB +: 3];
            OP_SLBI, OP_STU, OP_LBI:              d.rd = instr[RS_LSB +: 3];
            OP_JAL, OP_JALR:                      d.rd = 3'd7;
            default: begin
                d.en = 1'b0;
                d.rd = '0;
            end
        endcase
        return d;
    endfunction

    function automatic logic uses_rs(input opcode_t op);
        return !(op inside {OP_HALT, OP_NOP, OP_J, OP_JAL, OP_LBI});
    endfunction

    function automatic logic uses_rt(input opcode_t op);
        logic u;
        casez (op)
            OP_ARITH, OP_SHIFT, 5'b111??, OP_ST, OP_STU: u = 1'b1;
            default:                                     u = 1'b0;
        endcase
        return u;
    endfunction
endpackage

// File: rtl/regfile_8x16.sv
// 8x16 register file: two combinational read ports that see a same-cycle write,
// one clocked write port, cleared by reset.
module regfile_8x16 import wisc_pkg::*; (
    input  logic     clk,
    input  logic     rst_n,
    input  regspec_t rd_a_reg,
    output word_t    rd_a_data,
    input  regspec_t rd_b_reg,
    output word_t    rd_b_data,
    input  logic     wr_en,
    input  regspec_t wr_reg,
    input  word_t    wr_data
);
    word_t mem [8];

    for (genvar gi = 0; gi < 8; gi++) begin : g_word
        word_t word_reg;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                word_reg <= '0;
            end else if (wr_en && wr_reg == regspec_t'(gi)) begin
                word_reg <= wr_data;
            end
        end

        assign mem[gi] = word_reg;
    end

    assign rd_a_data = (wr_en && wr_reg == rd_a_reg) ? wr_data : mem[rd_a_reg];
    assign rd_b_data = (wr_en && wr_reg == rd_b_reg) ? wr_data : mem[rd_b_reg];
endmodule

// File: rtl/decode_issue.sv
// Decode/issue stage: splits WISC instructions, reads operands, tracks outstanding
// register writes to stall on RAW hazards and issues a registered bundle to execute.
module decode_issue import wisc_pkg::*; #(
    parameter int NREG   = 8,
    parameter int PEND_W = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 if_valid,
    input  logic [15:0]          if_instr,
    input  logic [15:0]          if_pc,
    output logic                 if_ready,
    output logic                 ex_valid,
    input  logic                 ex_ready,
    output logic [4:0]           ex_opcode,
    output logic [1:0]           ex_funct,
    output logic [15:0]          ex_rs_data,
    output logic [15:0]          ex_rt_data,
    output logic [15:0]          ex_pc,
    output logic [IMM_W-1:0]     ex_imm,
    output logic                 ex_wr_en,
    output logic [2:0]           ex_wr_reg,
    input  logic                 wb_en,
    input  logic [2:0]           wb_reg,
    input  logic [15:0]          wb_data,
    input  logic                 flush,
    output logic                 halted
);
    opcode_t           op;
    regspec_t          rs;
    regspec_t          rt;
    dest_t             dest;
    word_t             rs_data;
    word_t             rt_data;
    logic              hazard;
    logic              accept;
    logic              drop;
    logic [PEND_W-1:0] pend [NREG];

    assign op   = opcode_of(if_instr);
    assign rs   = rs_of(if_instr);
    assign rt   = rt_of(if_instr);
    assign dest = decode_dest(if_instr);

    regfile_8x16 u_rf (
        .clk       (clk),
        .rst_n     (rst_n),
        .rd_a_reg  (rs),
        .rd_a_data (rs_data),
        .rd_b_reg  (rt),
        .rd_b_data (rt_data),
        .wr_en     (wb_en),
        .wr_reg    (wb_reg),
        .wr_data   (wb_data)
    );

    // Counts are sampled before this cycle's write-back, so a retiring write only unblocks next cycle.
    assign hazard = (uses_rs(op) && pend[rs] != '0)
                 || (uses_rt(op) && pend[rt] != '0)
                 || (dest.en && pend[dest.rd] == '1);

    assign if_ready = ~halted & ~hazard & ~flush & (~ex_valid | ex_ready);
    assign accept   = if_valid & if_ready;
    assign drop     = flush & ex_valid & ~ex_ready;

    for (genvar gi = 0; gi < NREG; gi++) begin : g_pend
        logic              inc;
        logic              wb_dec;
        logic              fl_dec;
        logic [PEND_W:0]   sum;
        logic [PEND_W:0]   sub;
        logic [PEND_W-1:0] cnt_reg;

        assign inc    = accept & dest.en & (dest.rd == regspec_t'(gi));
        assign wb_dec = wb_en & (wb_reg == regspec_t'(gi));
        assign fl_dec = drop & ex_wr_en & (ex_wr_reg == regspec_t'(gi));
        assign sum    = (PEND_W+1)'(cnt_reg) + (PEND_W+1)'(inc);
        assign sub    = (PEND_W+1)'(wb_dec) + (PEND_W+1)'(fl_dec);

        // Clamp at zero: a write-back with nothing outstanding must not wrap the count.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                cnt_reg <= '0;
            end else if (sum > sub) begin
                cnt_reg <= PEND_W'(sum - sub);
            end else begin
                cnt_reg <= '0;
            end
        end

        assign pend[gi] = cnt_reg;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid   <= 1'b0;
            ex_opcode  <= '0;
            ex_funct   <= '0;
            ex_rs_data <= '0;
            ex_rt_data <= '0;
            ex_pc      <= '0;
            ex_imm     <= '0;
            ex_wr_en   <= 1'b0;
            ex_wr_reg  <= '0;
            halted     <= 1'b0;
        end else if (accept) begin
            ex_valid   <= 1'b1;
            ex_opcode  <= op;
            ex_funct   <= if_instr[1:0];
            ex_rs_data <= rs_data;
            ex_rt_data <= rt_data;
            ex_pc      <= if_pc;
            ex_imm     <= if_instr[IMM_W-1:0];
            ex_wr_en   <= dest.en;
            ex_wr_reg  <= dest.rd;
            if (op == OP_HALT) begin
                halted <= 1'b1;
            end
        end else if (ex_ready || drop) begin
            ex_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_decode_issue.sv
// Self-checking bench for decode_issue: a scoreboard of expected bundles is filled on
// accept and drained when execute takes a bundle; scenario tasks add targeted checks.
module tb_decode_issue;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        if_valid;
    logic [15:0] if_instr;
    logic [15:0] if_pc;
    logic        if_ready;
    logic        ex_valid;
    logic        ex_ready;
    logic [4:0]  ex_opcode;
    logic [1:0]  ex_funct;
    logic [15:0] ex_rs_data;
    logic [15:0] ex_rt_data;
    logic [15:0] ex_pc;
    logic [10:0] ex_imm;
    logic        ex_wr_en;
    logic [2:0]  ex_wr_reg;
    logic        wb_en;
    logic [2:0]  wb_reg;
    logic [15:0] wb_data;
    logic        flush;
    logic        halted;

    always #5 clk = ~clk;

    decode_issue dut (
        .clk(clk), .rst_n(rst_n),
        .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc), .if_ready(if_ready),
        .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_opcode(ex_opcode), .ex_funct(ex_funct),
        .ex_rs_data(ex_rs_data), .ex_rt_data(ex_rt_data), .ex_pc(ex_pc), .ex_imm(ex_imm),
        .ex_wr_en(ex_wr_en), .ex_wr_reg(ex_wr_reg),
        .wb_en(wb_en), .wb_reg(wb_reg), .wb_data(wb_data),
        .flush(flush), .halted(halted)
    );

    typedef struct packed {
        logic [4:0]  opcode;
        logic [1:0]  funct;
        logic [15:0] rs;
        logic [15:0] rt;
        logic [15:0] pc;
        logic [10:0] imm;
        logic        wr_en;
        logic [2:0]  wr_reg;
    } bundle_t;

    bundle_t     sb[$];
    logic [15:0] model_rf [8];
    int          checks = 0;
    int          errors = 0;
    logic        seen_ready;
    logic        seen_accept;
    int          st;

    // {writes, register} from the destination table
    function automatic logic [3:0] exp_dest(input logic [15:0] ins);
        logic [4:0] op;
        op = ins[15:11];
        if (op == 5'b11011 || op == 5'b11010 || op[4:2] == 3'b111) return {1'b1, ins[4:2]};
        if (op[4:2] == 3'b010 || op[4:2] == 3'b101 || op == 5'b10001 || op == 5'b11001)
            return {1'b1, ins[7:5]};
        if (op == 5'b10010 || op == 5'b10011 || op == 5'b11000) return {1'b1, ins[10:8]};
        if (op == 5'b00110 || op == 5'b00111) return 4'b1111;
        return 4'b0000;
    endfunction

    // One clock: sample at the falling edge, update the model after the rising edge.
    task automatic tick();
        bundle_t     e;
        bundle_t     got;
        logic [3:0]  d;
        @(negedge clk);
        seen_ready  = if_ready;
        seen_accept = if_valid & if_ready;
        if (ex_valid && ex_ready) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL bundle_unexpected opcode=%b pc=%h", ex_opcode, ex_pc);
            end else begin
                e = sb.pop_front();
                got.opcode = ex_opcode;  got.funct = ex_funct;
                got.rs = ex_rs_data;     got.rt = ex_rt_data;
                got.pc = ex_pc;          got.imm = ex_imm;
                got.wr_en = ex_wr_en;    got.wr_reg = ex_wr_en ? ex_wr_reg : 3'd0;
                if (got !== e) begin
                    errors++;
                    $display("FAIL bundle got=%h required=%h", got, e);
                end
            end
        end else if (flush && ex_valid && !ex_ready && sb.size() > 0) begin
            sb.delete(0);
        end
        if (seen_accept) begin
            d = exp_dest(if_instr);
            e.opcode = if_instr[15:11];
            e.funct  = if_instr[1:0];
            e.rs     = (wb_en && wb_reg == if_instr[10:8]) ? wb_data : model_rf[if_instr[10:8]];
            e.rt     = (wb_en && wb_reg == if_instr[7:5])  ? wb_data : model_rf[if_instr[7:5]];
            e.pc     = if_pc;
            e.imm    = if_instr[10:0];
            e.wr_en  = d[3];
            e.wr_reg = d[3] ? d[2:0] : 3'd0;
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        if (wb_en) model_rf[wb_reg] = wb_data;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; if_valid = 1'b0; if_instr = '0; if_pc = '0;
        wb_en = 1'b0; wb_reg = '0; wb_data = '0; flush = 1'b0; ex_ready = 1'b1;
        #12;
        sb.delete();
        foreach (model_rf[i]) model_rf[i] = '0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic issue(input logic [15:0] ins, input logic [15:0] pc, output int stalls);
        if_valid = 1'b1; if_instr = ins; if_pc = pc; stalls = 0;
        tick();
        while (!seen_accept && stalls < 50) begin
            stalls++;
            tick();
        end
        if (!seen_accept) begin
            checks++; errors++;
            $display("FAIL issue_timeout instr=%h", ins);
        end
        if_valid = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({ex_valid, halted} !== 2'b00) begin
            errors++; $display("FAIL reset_flags got=%b required=00", {ex_valid, halted});
        end
        checks++;
        if ({ex_opcode, ex_funct, ex_rs_data, ex_rt_data, ex_pc, ex_imm, ex_wr_en, ex_wr_reg} !== '0) begin
            errors++; $display("FAIL reset_data opcode=%b pc=%h imm=%h required zero", ex_opcode, ex_pc, ex_imm);
        end
        checks++;
        if (if_ready !== 1'b1) begin
            errors++; $display("FAIL reset_ready got=%b required=1", if_ready);
        end
    endtask

    task automatic test_issue_basic();
        do_reset();
        wb_en = 1'b1; wb_reg = 3'd1; wb_data = 16'd5; tick();
        wb_reg = 3'd2; wb_data = 16'd7; tick();
        wb_en = 1'b0;
        issue(16'hD94C, 16'h0102, st);
        checks++;
        if (st != 0 || ex_valid !== 1'b1 || ex_rs_data !== 16'd5 || ex_rt_data !== 16'd7 ||
            ex_opcode !== 5'b11011 || ex_funct !== 2'b00 || ex_wr_reg !== 3'd3) begin
            errors++;
            $display("FAIL basic_add stalls=%0d valid=%b rs=%h rt=%h op=%b wr=%0d required 0 1 0005 0007 11011 3",
                     st, ex_valid, ex_rs_data, ex_rt_data, ex_opcode, ex_wr_reg);
        end
        if_valid = 1'b1; if_instr = 16'hDB74; if_pc = 16'h0104;
        tick();
        checks++;
        if (seen_ready !== 1'b0) begin errors++; $display("FAIL basic_raw_stall ready=%b required=0", seen_ready); end
        wb_en = 1'b1; wb_reg = 3'd3; wb_data = 16'h0009; tick();
        checks++;
        if (seen_ready !== 1'b0) begin errors++; $display("FAIL basic_wb_same_cycle ready=%b required=0", seen_ready); end
        wb_en = 1'b0; tick();
        checks++;
        if (seen_accept !== 1'b1) begin errors++; $display("FAIL basic_release accept=%b required=1", seen_accept); end
        if_valid = 1'b0; tick();
        checks++;
        if (ex_valid !== 1'b0) begin errors++; $display("FAIL basic_drain valid=%b required=0", ex_valid); end
    endtask

    task automatic test_raw_hazard();
        do_reset();
        wb_en = 1'b1; wb_reg = 3'd1; wb_data = 16'h0010; tick();
        wb_en = 1'b0;
        issue(16'h4143, 16'h0200, st);
        if_valid = 1'b1; if_instr = 16'hDA30; if_pc = 16'h0202;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (seen_ready !== 1'b0) begin errors++; $display("FAIL raw_wait%0d ready=%b required=0", i, seen_ready); end
        end
        wb_en = 1'b1; wb_reg = 3'd2; wb_data = 16'h0013; tick();
        checks++;
        if (seen_ready !== 1'b0) begin errors++; $display("FAIL raw_wb_cycle ready=%b required=0", seen_ready); end
        wb_en = 1'b0; tick();
        checks++;
        if (seen_accept !== 1'b1) begin errors++; $display("FAIL raw_accept accept=%b required=1", seen_accept); end
        if_valid = 1'b0;
        wb_en = 1'b1; wb_reg = 3'd1; wb_data = 16'h0055;
        issue(16'hD94C, 16'h0204, st);
        wb_en = 1'b0;
        checks++;
        if (st != 0) begin errors++; $display("FAIL raw_forward_stall stalls=%0d required=0", st); end
        issue(16'h4100, 16'h0206, st);
        checks++;
        if (st != 0) begin errors++; $display("FAIL raw_no_underflow stalls=%0d required=0", st); end
        tick(); tick();
    endtask

    task automatic test_backpressure();
        do_reset();
        ex_ready = 1'b0;
        issue(16'hC134, 16'h0300, st);
        if_valid = 1'b1; if_instr = 16'h0800; if_pc = 16'h0302;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (seen_ready !== 1'b0 || ex_valid !== 1'b1 || ex_imm !== 11'h134 ||
                ex_pc !== 16'h0300 || ex_opcode !== 5'b11000) begin
                errors++;
                $display("FAIL bp_hold%0d ready=%b valid=%b imm=%h pc=%h op=%b required 0 1 134 0300 11000",
                         i, seen_ready, ex_valid, ex_imm, ex_pc, ex_opcode);
            end
        end
        ex_ready = 1'b1; tick();
        checks++;
        if (seen_accept !== 1'b1 || ex_valid !== 1'b1 || ex_opcode !== 5'b00001 || ex_pc !== 16'h0302) begin
            errors++;
            $display("FAIL bp_same_edge accept=%b valid=%b op=%b pc=%h required 1 1 00001 0302",
                     seen_accept, ex_valid, ex_opcode, ex_pc);
        end
        if_valid = 1'b0; tick();
        checks++;
        if (ex_valid !== 1'b0) begin errors++; $display("FAIL bp_drain valid=%b required=0", ex_valid); end
    endtask

    task automatic test_flush();
        do_reset();
        ex_ready = 1'b0;
        issue(16'hC512, 16'h0400, st);
        tick();
        flush = 1'b1; tick();
        checks++;
        if (seen_ready !== 1'b0) begin errors++; $display("FAIL flush_ready ready=%b required=0", seen_ready); end
        flush = 1'b0;
        checks++;
        if (ex_valid !== 1'b0) begin errors++; $display("FAIL flush_drop valid=%b required=0", ex_valid); end
        ex_ready = 1'b1;
        issue(16'h4500, 16'h0402, st);
        checks++;
        if (st != 0) begin errors++; $display("FAIL flush_pending_cleared stalls=%0d required=0", st); end
        flush = 1'b1; tick();
        flush = 1'b0;
        if_valid = 1'b1; if_instr = 16'h4000; if_pc = 16'h0404;
        tick();
        checks++;
        if (seen_ready !== 1'b0) begin errors++; $display("FAIL flush_taken_kept ready=%b required=0", seen_ready); end
        if_valid = 1'b0;
    endtask

    task automatic test_pending_sat();
        do_reset();
        issue(16'hC601, 16'h0500, st);
        issue(16'hC602, 16'h0502, st);
        issue(16'hC603, 16'h0504, st);
        if_valid = 1'b1; if_instr = 16'hC604; if_pc = 16'h0506;
        tick();
        checks++;
        if (seen_ready !== 1'b0) begin errors++; $display("FAIL sat_fourth ready=%b required=0", seen_ready); end
        wb_en = 1'b1; wb_reg = 3'd6; wb_data = 16'h00AA; tick();
        checks++;
        if (seen_ready !== 1'b0) begin errors++; $display("FAIL sat_wb_cycle ready=%b required=0", seen_ready); end
        wb_en = 1'b0; tick();
        checks++;
        if (seen_accept !== 1'b1) begin errors++; $display("FAIL sat_unblock accept=%b required=1", seen_accept); end
        if_instr = 16'hC605; if_pc = 16'h0508;
        tick();
        checks++;
        if (seen_ready !== 1'b0) begin errors++; $display("FAIL sat_full_again ready=%b required=0", seen_ready); end
        wb_en = 1'b1; wb_data = 16'h00BB; tick();
        wb_data = 16'h00CC; tick();
        checks++;
        if (seen_accept !== 1'b1) begin errors++; $display("FAIL sat_issue_with_wb accept=%b required=1", seen_accept); end
        wb_en = 1'b0; if_instr = 16'hC606; if_pc = 16'h050A; tick();
        checks++;
        if (seen_accept !== 1'b1) begin errors++; $display("FAIL sat_count_kept accept=%b required=1", seen_accept); end
        if_instr = 16'h4600; if_pc = 16'h050C;
        wb_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            wb_data = 16'h00D1 + 16'(i);
            tick();
            checks++;
            if (seen_ready !== 1'b0) begin errors++; $display("FAIL sat_drain%0d ready=%b required=0", i, seen_ready); end
        end
        wb_en = 1'b0; tick();
        checks++;
        if (seen_accept !== 1'b1) begin errors++; $display("FAIL sat_reader accept=%b required=1", seen_accept); end
        if_valid = 1'b0;
        issue(16'hC607, 16'h050E, st);
    endtask

    task automatic test_halt();
        int ready_cnt;
        if_valid = 1'b1; if_instr = 16'h4600; if_pc = 16'h0600;
        tick();
        checks++;
        if (seen_ready !== 1'b0) begin errors++; $display("FAIL halt_pre_stall ready=%b required=0", seen_ready); end
        do_reset();
        issue(16'h4600, 16'h0600, st);
        checks++;
        if (st != 0 || ex_rs_data !== 16'h0000) begin
            errors++; $display("FAIL reset_mid_stall stalls=%0d rs=%h required 0 0000", st, ex_rs_data);
        end
        issue(16'h0000, 16'h0602, st);
        checks++;
        if (halted !== 1'b1) begin errors++; $display("FAIL halt_set halted=%b required=1", halted); end
        if_valid = 1'b1; if_instr = 16'h0800; if_pc = 16'h0604;
        ready_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (seen_ready) ready_cnt++;
        end
        checks++;
        if (ready_cnt != 0 || halted !== 1'b1) begin
            errors++; $display("FAIL halt_hold ready_cycles=%0d halted=%b required 0 1", ready_cnt, halted);
        end
        do_reset();
        checks++;
        if (halted !== 1'b0 || ex_valid !== 1'b0) begin
            errors++; $display("FAIL halt_reset halted=%b valid=%b required 0 0", halted, ex_valid);
        end
        issue(16'h0800, 16'h0606, st);
        checks++;
        if (st != 0) begin errors++; $display("FAIL halt_after_reset stalls=%0d required=0", st); end
        tick();
    endtask

    initial begin
        test_reset();
        test_issue_basic();
        test_raw_hazard();
        test_backpressure();
        test_flush();
        test_pending_sat();
        test_halt();
        checks++;
        if (sb.size() != 0) begin errors++; $display("FAIL scoreboard_leftover entries=%0d required=0", sb.size()); end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
